esdi_read_serializer: RTL and testbench
=======================================

Name: esdi_read_serializer

Overview:
Transmit-side counterpart of the ESDI write capture path. It accepts sector bytes from the PS over an AXI-Stream slave and serializes them MSB-first onto the ESDI read data/clock pair, aligned to the emulated index/sector timing (cycle_count). It also drives read_data_valid / esdi_read_data_ungated, the bit-strobe the write capture path samples when write gate is not asserted.

Parameters:
CLKS_PER_BIT, 10, aclk cycles per ESDI bit cell (even, >=4)
START_CYCLE, 2, cycle_count value that starts a sector

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
enable  in  1  block enable; 0 forces IDLE
sector_length  in  10  bytes per sector (unformatted), >=1
sector_number  in  8  current sector from timing block
cycle_count  in  32  cycle position within sector
status_clear  in  1  one-cycle pulse, clears sticky flags
parallel_tvalid  in  1  stream valid
parallel_tready  out  1  stream ready
parallel_tdata  in  8  sector byte
parallel_tlast  in  1  last byte of sector frame
parallel_tid  in  8  sector number of frame
esdi_read_data  out  1  serialized data (0 outside sector)
esdi_read_clock  out  1  ESDI read clock
esdi_read_data_ungated  out  1  same as esdi_read_data, for loopback
read_data_valid  out  1  one-cycle strobe per bit cell start
sector_done  out  1  one-cycle pulse after last bit cell
underrun  out  1  sticky: byte needed, none buffered
tid_mismatch  out  1  sticky: frame tid != latched sector
frame_error  out  1  sticky: tlast early or late

Behaviour:
- Reset (async, aresetn=0): all outputs 0, state IDLE, hold buffer empty, counters 0. Release is synchronous to aclk.
- Bit-cell phase counter p (0..CLKS_PER_BIT-1) free-runs while enable=1; held at 0 when enable=0. esdi_read_clock = (p >= CLKS_PER_BIT/2), registered.
- States: IDLE, WAIT_START, SHIFT, DISCARD.
- IDLE -> WAIT_START when enable=1.
- WAIT_START: on cycle_count==START_CYCLE: latch sector_number, zero bit/byte counters, force p=0 next cycle, go SHIFT.
- SHIFT: at each p==0, drive next shift-register bit onto esdi_read_data and esdi_read_data_ungated, assert read_data_valid for that single cycle. Data stable for the whole cell.
- Byte load: when 8 bits have been shifted (or at first cell), load the shift register from the hold buffer. Hold empty at that point -> shift register loads 0x00, underrun<=1.
- Per frame: first byte's tid compared to latched sector; mismatch -> tid_mismatch<=1, state DISCARD (the remaining bits of the sector output as 0).
- Byte count reaching sector_length without the consumed byte carrying tlast -> frame_error<=1, remaining frame bytes dropped until tlast. tlast on a byte before sector_length -> frame_error<=1, remaining bytes of the sector output as 0x00 (no underrun flagged for them).
- After the last bit cell of sector_length*8 completes: sector_done pulses 1 cycle, esdi_read_data=0, go WAIT_START.
- DISCARD: parallel_tready=1, drop beats until tlast accepted. Sector timing continues with zeros. Return to WAIT_START at the sector end.
- parallel_tready = enable & (hold empty, or the hold is being loaded into the shift register this cycle), or 1 when dropping. Single-entry hold buffer, so one full byte of prefetch.
- Prefetch is allowed in WAIT_START, so the first byte can be buffered before START_CYCLE.
- Simultaneous status_clear and a flag set: the set wins.
- enable 1->0 mid-sector: next cycle IDLE, data/valid 0, clock held low, hold buffer flushed, sticky flags kept.
- Any cycle_count==START_CYCLE while in SHIFT (sector overrun by timing): restart at the new sector, frame_error<=1.

Test Plan:
- CLKS_PER_BIT=4, sector_length=2, tid=5, sector_number=5, bytes 0xA5,0x3C(tlast) -> esdi_read_data 1010010100111100 across 16 cells, 16 read_data_valid strobes 4 cycles apart, sector_done once, all flags 0.
- No stream data, sector_length=1 -> 8 zero bits, underrun=1, sector_done pulses. status_clear -> underrun=0.
- tid=7, sector_number=5, 2-byte frame -> tid_mismatch=1, output all zeros, both beats accepted, next sector with tid=6, sector_number=6 transmits correctly.
- Frame of 3 bytes with sector_length=2 -> first 2 bytes sent, frame_error=1, third byte dropped. Frame of 1 byte (tlast) with sector_length=2 -> second byte 0x00, frame_error=1, underrun=0.
- Deassert enable after 5 bits -> outputs 0 the next cycle, parallel_tready=0. Re-enable -> waits for START_CYCLE.
- Assert aresetn=0 asynchronously mid-cell -> all outputs 0 immediately without a clock edge. After release, the nominal sector passes.

Source files
------------

// File: rtl/esdi_read_serializer.sv
// ESDI read-path serializer: turns AXI-Stream sector bytes into an MSB-first
// bit stream on the ESDI read data/clock pair, aligned to the sector timing.
// read_data_valid marks the first aclk of each bit cell for the write capture
// loopback. Bytes pass through a single-entry hold buffer, so one byte can be
// prefetched before the sector starts.
module esdi_read_serializer #(
   parameter int CLKS_PER_BIT = 10,
   parameter int START_CYCLE  = 2
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic        enable,
   input  logic [9:0]  sector_length,
   input  logic [7:0]  sector_number,
   input  logic [31:0] cycle_count,
   input  logic        status_clear,
   input  logic        parallel_tvalid,
   output logic        parallel_tready,
   input  logic [7:0]  parallel_tdata,
   input  logic        parallel_tlast,
   input  logic [7:0]  parallel_tid,
   output logic        esdi_read_data,
   output logic        esdi_read_clock,
   output logic        esdi_read_data_ungated,
   output logic        read_data_valid,
   output logic        sector_done,
   output logic        underrun,
   output logic        tid_mismatch,
   output logic        frame_error
);

   localparam int              PW     = $clog2(CLKS_PER_BIT);
   localparam logic [PW-1:0]   P_LAST = PW'(CLKS_PER_BIT - 1);
   localparam logic [PW-1:0]   P_HALF = PW'(CLKS_PER_BIT / 2);

   typedef enum logic [1:0] {IDLE, WAIT_START, SHIFT, DISCARD} state_t;

   state_t        state, state_next;

   logic [PW-1:0] phase, phase_next;
   logic [12:0]   bit_idx;
   logic [12:0]   total_bits;
   logic [9:0]    byte_num;
   logic [7:0]    shreg;
   logic [7:0]    latched_sector;

   logic          hold_full, hold_last;
   logic [7:0]    hold_data, hold_tid;
   logic          dropping, frame_start;

   logic          data_p1, valid_p1, done_p1, clock_p1;
   logic          underrun_q, tid_mismatch_q, frame_error_q;

   logic          cc_hit, start_hit, restart, sector_end, cell_start;
   logic          byte_load, load_hold, tid_bad, early_last, late_last;
   logic          underrun_set, drop_set;
   logic [7:0]    load_byte;
   logic          out_bit;
   logic          beat_fire, beat_drop;

   assign total_bits = {sector_length, 3'b000};
   assign byte_num   = bit_idx[12:3] + 10'd1;
   assign cc_hit     = (cycle_count == 32'(START_CYCLE));

   // State register; reset and disable both land in IDLE.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         state <= IDLE;
      else
         state <= state_next;
   end

   // Next state plus per-cycle decisions: sector start/restart, cell start, byte load and frame checks.
   always_comb begin
      state_next   = state;
      start_hit    = 1'b0;
      restart      = 1'b0;
      sector_end   = 1'b0;
      cell_start   = 1'b0;
      byte_load    = 1'b0;
      load_hold    = 1'b0;
      tid_bad      = 1'b0;
      early_last   = 1'b0;
      late_last    = 1'b0;
      underrun_set = 1'b0;
      drop_set     = 1'b0;
      load_byte    = 8'h00;
      if (!enable) begin
         state_next = IDLE;
      end else begin
         case (state)
            IDLE: state_next = WAIT_START;
            WAIT_START: begin
               if (cc_hit) begin
                  start_hit  = 1'b1;
                  state_next = SHIFT;
               end
            end
            SHIFT, DISCARD: begin
               if (cc_hit) begin
                  // Timing wrapped before this sector finished: start over on the new one.
                  start_hit  = 1'b1;
                  restart    = 1'b1;
                  state_next = SHIFT;
               end else if (phase == '0) begin
                  if (bit_idx == total_bits) begin
                     sector_end = 1'b1;
                     state_next = WAIT_START;
                  end else begin
                     cell_start = 1'b1;
                     // DISCARD never loads; the shift register has already drained to zeros.
                     if (bit_idx[2:0] == 3'd0 && state == SHIFT) begin
                        byte_load = 1'b1;
                        if (!hold_full) begin
                           underrun_set = 1'b1;
                        end else begin
                           load_hold = 1'b1;
                           if (frame_start && hold_tid != latched_sector) begin
                              tid_bad    = 1'b1;
                              state_next = DISCARD;
                              drop_set   = !hold_last;
                           end else begin
                              load_byte = hold_data;
                              if (hold_last && byte_num != sector_length) begin
                                 early_last = 1'b1;
                                 state_next = DISCARD;
                              end else if (!hold_last && byte_num == sector_length) begin
                                 late_last = 1'b1;
                                 drop_set  = 1'b1;
                              end
                           end
                        end
                     end
                  end
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   // Bit-cell phase: free-running, realigned to 0 at sector start, parked at 0 while disabled.
   always_comb begin
      phase_next = '0;
      if (enable && !start_hit)
         phase_next = (phase == P_LAST) ? '0 : phase + 1'b1;
   end

   assign out_bit         = byte_load ? load_byte[7] : shreg[7];
   assign parallel_tready = enable && (state != IDLE) && (dropping || !hold_full || load_hold);
   assign beat_fire       = parallel_tvalid && parallel_tready;
   assign beat_drop       = dropping || drop_set;

   // Control and output registers: phase, bit counter, line outputs, hold occupancy, frame tracking.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         phase       <= '0;
         bit_idx     <= '0;
         data_p1     <= 1'b0;
         valid_p1    <= 1'b0;
         done_p1     <= 1'b0;
         clock_p1    <= 1'b0;
         hold_full   <= 1'b0;
         dropping    <= 1'b0;
         frame_start <= 1'b1;
      end else if (!enable) begin
         phase       <= '0;
         bit_idx     <= '0;
         data_p1     <= 1'b0;
         valid_p1    <= 1'b0;
         done_p1     <= 1'b0;
         clock_p1    <= 1'b0;
         hold_full   <= 1'b0;
         dropping    <= 1'b0;
         frame_start <= 1'b1;
      end else begin
         phase    <= phase_next;
         clock_p1 <= (phase_next >= P_HALF);
         valid_p1 <= cell_start;
         done_p1  <= sector_end;
         if (start_hit) begin
            bit_idx <= '0;
            data_p1 <= 1'b0;
         end else if (sector_end) begin
            data_p1 <= 1'b0;
         end else if (cell_start) begin
            bit_idx <= bit_idx + 13'd1;
            data_p1 <= out_bit;
         end
         if (beat_fire && !beat_drop)
            hold_full <= 1'b1;
         else if (load_hold)
            hold_full <= 1'b0;
         // A tlast dropped in the same cycle must override the consumed byte's frame_start.
         if (load_hold)
            frame_start <= hold_last;
         if (beat_fire && beat_drop && parallel_tlast)
            frame_start <= 1'b1;
         dropping <= beat_drop && !(beat_fire && parallel_tlast);
      end
   end

   // Data-only registers: shift register, hold buffer contents and latched sector number.
   always_ff @(posedge aclk) begin
      if (start_hit)
         latched_sector <= sector_number;
      if (cell_start)
         shreg <= byte_load ? {load_byte[6:0], 1'b0} : {shreg[6:0], 1'b0};
      if (beat_fire && !beat_drop) begin
         hold_data <= parallel_tdata;
         hold_tid  <= parallel_tid;
         hold_last <= parallel_tlast;
      end
   end

   // Sticky status flags; a set in the same cycle as status_clear wins, and disable keeps them.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         underrun_q     <= 1'b0;
         tid_mismatch_q <= 1'b0;
         frame_error_q  <= 1'b0;
      end else begin
         underrun_q     <= (underrun_q && !status_clear) || underrun_set;
         tid_mismatch_q <= (tid_mismatch_q && !status_clear) || tid_bad;
         frame_error_q  <= (frame_error_q && !status_clear) || early_last || late_last || restart;
      end
   end

   assign esdi_read_data         = data_p1;
   assign esdi_read_data_ungated = data_p1;
   assign esdi_read_clock        = clock_p1;
   assign read_data_valid        = valid_p1;
   assign sector_done            = done_p1;
   assign underrun               = underrun_q;
   assign tid_mismatch           = tid_mismatch_q;
   assign frame_error            = frame_error_q;

endmodule

// File: tb/tb_esdi_read_serializer.sv
// Scoreboard bench for esdi_read_serializer: expected bits are queued when a
// sector is set up, and a negedge monitor pops one per read_data_valid strobe.
module tb_esdi_read_serializer;

   localparam int CPB = 4;
   localparam int SC  = 2;

   logic        aclk = 1'b0;
   logic        aresetn = 1'b0;
   logic        enable = 1'b0;
   logic [9:0]  sector_length = 10'd0;
   logic [7:0]  sector_number = 8'd0;
   logic [31:0] cycle_count = 32'd100;
   logic        status_clear = 1'b0;
   logic        parallel_tvalid = 1'b0;
   logic        parallel_tready;
   logic [7:0]  parallel_tdata = 8'd0;
   logic        parallel_tlast = 1'b0;
   logic [7:0]  parallel_tid = 8'd0;
   logic        esdi_read_data, esdi_read_clock, esdi_read_data_ungated;
   logic        read_data_valid, sector_done, underrun, tid_mismatch, frame_error;

   int total = 0;
   int bad = 0;
   int strobes = 0;
   int cyc = 0;
   int last_strobe = -100;
   bit drv_done = 1'b1;
   bit exp_q[$];

   esdi_read_serializer #(.CLKS_PER_BIT(CPB), .START_CYCLE(SC)) dut (
      .aclk(aclk), .aresetn(aresetn), .enable(enable),
      .sector_length(sector_length), .sector_number(sector_number),
      .cycle_count(cycle_count), .status_clear(status_clear),
      .parallel_tvalid(parallel_tvalid), .parallel_tready(parallel_tready),
      .parallel_tdata(parallel_tdata), .parallel_tlast(parallel_tlast),
      .parallel_tid(parallel_tid),
      .esdi_read_data(esdi_read_data), .esdi_read_clock(esdi_read_clock),
      .esdi_read_data_ungated(esdi_read_data_ungated),
      .read_data_valid(read_data_valid), .sector_done(sector_done),
      .underrun(underrun), .tid_mismatch(tid_mismatch), .frame_error(frame_error)
   );

   always #5 aclk = ~aclk;

   always @(posedge aclk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every strobe pops one expected bit; strobes within a sector are CPB cycles apart.
   initial begin
      bit b;
      forever begin
         @(negedge aclk);
         if (aresetn && read_data_valid) begin
            strobes++;
            if (cyc - last_strobe < 20)
               check("strobe_gap", cyc - last_strobe, CPB);
            last_strobe = cyc;
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_strobe: got data=%0b expected no strobe", esdi_read_data);
            end else begin
               b = exp_q.pop_front();
               check("bit", esdi_read_data, b);
               check("bit_ungated", esdi_read_data_ungated, b);
            end
         end
      end
   end

   task automatic push_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) exp_q.push_back(v[i]);
   endtask

   task automatic drive_frame(input logic [7:0] tid, input int n,
                              input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
      logic [7:0] bytes [3];
      int waited;
      bytes[0] = b0;
      bytes[1] = b1;
      bytes[2] = b2;
      drv_done = 1'b0;
      @(posedge aclk);
      #1;
      for (int i = 0; i < n; i++) begin
         parallel_tvalid = 1'b1;
         parallel_tdata  = bytes[i];
         parallel_tlast  = (i == n - 1);
         parallel_tid    = tid;
         waited = 0;
         @(negedge aclk);
         while (!parallel_tready && waited < 300) begin
            @(negedge aclk);
            waited++;
         end
         if (!parallel_tready) begin
            total++;
            bad++;
            $display("FAIL beat_timeout: got tready=0 expected beat %0d accepted", i);
            parallel_tvalid = 1'b0;
            return;
         end
         @(posedge aclk);
         #1;
      end
      parallel_tvalid = 1'b0;
      parallel_tlast  = 1'b0;
      drv_done = 1'b1;
   endtask

   task automatic start_sector();
      repeat (16) @(posedge aclk);
      #1 cycle_count = SC;
      @(posedge aclk);
      #1 cycle_count = 32'd100;
   endtask

   task automatic wait_done(input string name);
      int n;
      n = 0;
      @(negedge aclk);
      #1;
      while (!sector_done && n < 400) begin
         @(negedge aclk);
         #1;
         n++;
      end
      check({name, "_done"}, sector_done, 1);
      @(negedge aclk);
      #1;
      check({name, "_done_single"}, sector_done, 0);
      check({name, "_data_idle"}, esdi_read_data, 0);
   endtask

   task automatic run_sector(input string name, input int exp_strobes);
      int base;
      base = strobes;
      start_sector();
      wait_done(name);
      check({name, "_strobes"}, strobes - base, exp_strobes);
      check({name, "_queue"}, exp_q.size(), 0);
   endtask

   task automatic pulse_clear();
      @(posedge aclk);
      #1 status_clear = 1'b1;
      @(posedge aclk);
      #1 status_clear = 1'b0;
   endtask

   task automatic wait_strobes(input int target);
      int n;
      n = 0;
      while (strobes < target && n < 300) begin
         @(negedge aclk);
         #1;
         n++;
      end
      check("strobe_wait", (strobes >= target), 1);
   endtask

   initial begin
      int base;
      repeat (3) @(posedge aclk);
      #1;
      check("reset_outputs", {parallel_tready, esdi_read_data, esdi_read_clock, esdi_read_data_ungated,
                              read_data_valid, sector_done, underrun, tid_mismatch, frame_error}, 0);
      @(negedge aclk) aresetn = 1'b1;
      enable = 1'b1;

      // Nominal two-byte sector.
      sector_length = 10'd2;
      sector_number = 8'd5;
      push_byte(8'hA5);
      push_byte(8'h3C);
      fork drive_frame(8'd5, 2, 8'hA5, 8'h3C, 8'h00); join_none
      run_sector("nominal", 16);
      check("nominal_accepted", drv_done, 1);
      check("nominal_flags", {underrun, tid_mismatch, frame_error}, 3'b000);

      // No stream data: zeros and underrun, then clear.
      sector_length = 10'd1;
      push_byte(8'h00);
      run_sector("underrun", 8);
      check("underrun_set", underrun, 1);
      pulse_clear();
      check("underrun_clear", underrun, 0);

      // Wrong tid: whole sector zero, frame swallowed, next sector fine.
      sector_length = 10'd2;
      push_byte(8'h00);
      push_byte(8'h00);
      fork drive_frame(8'd7, 2, 8'h11, 8'h22, 8'h00); join_none
      run_sector("tid_bad", 16);
      check("tid_mismatch_set", tid_mismatch, 1);
      check("tid_bad_accepted", drv_done, 1);
      check("tid_bad_frame_error", frame_error, 0);
      pulse_clear();
      check("tid_mismatch_clear", tid_mismatch, 0);
      sector_number = 8'd6;
      push_byte(8'h96);
      push_byte(8'h0F);
      fork drive_frame(8'd6, 2, 8'h96, 8'h0F, 8'h00); join_none
      run_sector("after_tid", 16);
      check("after_tid_flags", {underrun, tid_mismatch, frame_error}, 3'b000);

      // Frame longer than sector: third byte dropped.
      push_byte(8'hC3);
      push_byte(8'h5A);
      fork drive_frame(8'd6, 3, 8'hC3, 8'h5A, 8'hFF); join_none
      run_sector("long_frame", 16);
      check("long_frame_error", frame_error, 1);
      check("long_frame_accepted", drv_done, 1);
      check("long_frame_underrun", underrun, 0);
      pulse_clear();

      // Frame shorter than sector: zero fill without underrun.
      push_byte(8'h81);
      push_byte(8'h00);
      fork drive_frame(8'd6, 1, 8'h81, 8'h00, 8'h00); join_none
      run_sector("short_frame", 16);
      check("short_frame_error", frame_error, 1);
      check("short_frame_underrun", underrun, 0);
      pulse_clear();
      check("short_frame_clear", frame_error, 0);

      // Disable after five bits.
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
      fork drive_frame(8'd6, 2, 8'hF0, 8'h0F, 8'h00); join_none
      base = strobes;
      start_sector();
      wait_strobes(base + 5);
      enable = 1'b0;
      @(negedge aclk);
      #1;
      check("disable_outputs", {esdi_read_data, esdi_read_data_ungated, read_data_valid,
                                esdi_read_clock, parallel_tready, sector_done}, 0);
      check("disable_accepted", drv_done, 1);
      check("disable_queue", exp_q.size(), 0);
      enable = 1'b1;
      base = strobes;
      repeat (30) @(negedge aclk);
      #1;
      check("reenable_waits", strobes - base, 0);
      push_byte(8'hA5);
      push_byte(8'h3C);
      fork drive_frame(8'd6, 2, 8'hA5, 8'h3C, 8'h00); join_none
      run_sector("reenable", 16);
      check("reenable_flags", {underrun, tid_mismatch, frame_error}, 3'b000);

      // Asynchronous reset in the middle of a bit cell.
      push_byte(8'hA5);
      push_byte(8'h3C);
      fork drive_frame(8'd6, 2, 8'hA5, 8'h3C, 8'h00); join_none
      base = strobes;
      start_sector();
      wait_strobes(base + 3);
      #2 aresetn = 1'b0;
      #1;
      check("async_reset_outputs", {parallel_tready, esdi_read_data, esdi_read_clock, esdi_read_data_ungated,
                                    read_data_valid, sector_done, underrun, tid_mismatch, frame_error}, 0);
      exp_q.delete();
      repeat (2) @(posedge aclk);
      @(negedge aclk) aresetn = 1'b1;
      repeat (10) @(negedge aclk);
      push_byte(8'hA5);
      push_byte(8'h3C);
      fork drive_frame(8'd6, 2, 8'hA5, 8'h3C, 8'h00); join_none
      run_sector("after_reset", 16);
      check("after_reset_flags", {underrun, tid_mismatch, frame_error}, 3'b000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
